// File: rtl/sc_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// sc_matmul_sequencer
//
// Runs one stochastic matrix-multiply pass: enables the upstream stochastic
// number generators and walks the dot-product mux select for STREAM_LENGTH
// cycles, waits LATENCY cycles for the datapath to drain, and counts the ones
// on every output stream over the latency-shifted window. The finished
// M x O count vector is offered to the write-back stage on valid/ready.
//
// Ports
//   clk            in   clock, all state on the rising edge
//   rst            in   asynchronous, active-low reset
//   start          in   begin a pass (honoured only in IDLE)
//   busy           out  high while streaming or draining
//   streamEn       out  SNG enable, high only while streaming
//   sel            out  dot-product mux select, 0 outside streaming
//   outputStreams  in   datapath result bits, index i*O+j
//   outputWriteEn  in   datapath output qualifier
//   results        out  count k at [k*COUNT_WIDTH +: COUNT_WIDTH]
//   resultValid    out  results complete and stable
//   resultReady    in   consumer accepts results
// -----------------------------------------------------------------------------
module sc_matmul_sequencer #(
    parameter int BATCH_SIZE      = 4,
    parameter int OUTPUT_FEATURES = 4,
    parameter int SELECT_WIDTH    = 2,
    parameter int STREAM_LENGTH   = 256,
    parameter int LATENCY         = 2,
    parameter int COUNT_WIDTH     = $clog2(STREAM_LENGTH + 1)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              streamEn,
    output logic [SELECT_WIDTH-1:0]                           sel,
    input  logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]             outputStreams,
    input  logic                                              outputWriteEn,
    output logic [BATCH_SIZE*OUTPUT_FEATURES*COUNT_WIDTH-1:0] results,
    output logic                                              resultValid,
    input  logic                                              resultReady
);

    localparam int N     = BATCH_SIZE * OUTPUT_FEATURES;
    // One counter serves both the stream phase and the drain phase.
    localparam int CNT_W = $clog2(STREAM_LENGTH + LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                busy_q, busy_d;
    logic                                stream_en_q, stream_en_d;
    logic [SELECT_WIDTH-1:0]             sel_q, sel_d;
    logic                                valid_q, valid_d;
    logic [LATENCY-1:0]                  win_q, win_d;
    logic [N-1:0][COUNT_WIDTH-1:0]       counts_q, counts_d;
    logic                                count_en_s;
    logic                                start_acc_s;

    assign start_acc_s = (state_q == ST_IDLE) && start;
    // The count window is streamEn delayed by the datapath latency.
    assign count_en_s  = win_q[LATENCY-1];

    // Next-state and phase-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (cnt_q == CNT_W'(STREAM_LENGTH - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (resultReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        busy_d      = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
        stream_en_d = (state_d == ST_STREAM);
        valid_d     = (state_d == ST_DONE);
        if (state_d == ST_STREAM) begin
            sel_d = cnt_d[SELECT_WIDTH-1:0];
        end else begin
            sel_d = {SELECT_WIDTH{1'b0}};
        end
    end

    // Latency shift register feeding the count window.
    always_comb begin
        win_d    = win_q;
        win_d[0] = stream_en_q;
        for (int i = 1; i < LATENCY; i++) begin
            win_d[i] = win_q[i-1];
        end
    end

    // Per-stream ones counters; cleared on start accept, otherwise count
    // qualified ones inside the window. No overflow is possible.
    always_comb begin
        counts_d = counts_q;
        for (int k = 0; k < N; k++) begin
            if (start_acc_s) begin
                counts_d[k] = {COUNT_WIDTH{1'b0}};
            end else if (count_en_s && outputWriteEn && outputStreams[k]) begin
                counts_d[k] = counts_q[k] + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                counts_d[k] = counts_q[k];
            end
        end
    end

    // Control state, phase counter and registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            stream_en_q <= 1'b0;
            sel_q       <= {SELECT_WIDTH{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            stream_en_q <= stream_en_d;
            sel_q       <= sel_d;
            valid_q     <= valid_d;
        end
    end

    // Count window shift register and result counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q    <= {LATENCY{1'b0}};
            counts_q <= {(N*COUNT_WIDTH){1'b0}};
        end else begin
            win_q    <= win_d;
            counts_q <= counts_d;
        end
    end

    assign busy        = busy_q;
    assign streamEn    = stream_en_q;
    assign sel         = sel_q;
    assign resultValid = valid_q;
    assign results     = counts_q;

endmodule

// File: tb/tb_sc_matmul_sequencer.sv
module tb_sc_matmul_sequencer;

    localparam int M  = 2;
    localparam int O  = 2;
    localparam int SW = 2;
    localparam int S  = 16;
    localparam int L  = 2;
    localparam int N  = M * O;
    localparam int CW = $clog2(S + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              streamEn;
    logic [SW-1:0]     sel;
    logic [N-1:0]      outputStreams = '0;
    logic              outputWriteEn = 1'b1;
    logic [N*CW-1:0]   results;
    logic              resultValid;
    logic              resultReady = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [N*CW-1:0] exp_q[$];
    logic [N*CW-1:0] last_exp = '0;
    int              model_cnt[N];

    sc_matmul_sequencer #(
        .BATCH_SIZE(M), .OUTPUT_FEATURES(O), .SELECT_WIDTH(SW),
        .STREAM_LENGTH(S), .LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .streamEn(streamEn),
        .sel(sel), .outputStreams(outputStreams), .outputWriteEn(outputWriteEn),
        .results(results), .resultValid(resultValid), .resultReady(resultReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive the inputs that the DUT samples at edge k+t (k = start-accept
    // edge) and account for them in the model if that edge is a count edge.
    task automatic drive(input int pat, input int t);
        int   w;
        bit   in_win;
        logic [N-1:0] b;
        logic we;
        w      = t - L;
        in_win = (w >= 1) && (w <= S);
        b      = N'($urandom);
        we     = 1'b1;
        case (pat)
            0: b = '1;
            1: begin
                b[0] = 1'b1;
                if (in_win) b[1] = w[0];
                b[2] = 1'b0;
                b[3] = (in_win && w <= 4) || t == 1 || t == 2;
            end
            2: begin
                b  = '1;
                we = !(in_win && (w == 3 || w == 7 || w == 11));
            end
            default: we = 1'($urandom);
        endcase
        outputStreams = b;
        outputWriteEn = we;
        if (in_win && we)
            for (int k = 0; k < N; k++)
                if (b[k]) model_cnt[k]++;
    endtask

    function automatic logic [N*CW-1:0] pack_model();
        logic [N*CW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*CW +: CW] = CW'(model_cnt[k]);
        return v;
    endfunction

    // One pass starting just after an edge with the DUT idle.
    // bp = cycles of resultReady low in DONE; abort_n >= 0 resets mid-stream.
    task automatic run_pass(input int pat, input int bp, input int abort_n);
        for (int k = 0; k < N; k++) model_cnt[k] = 0;
        start = 1'b1;
        drive(pat, 0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < S + L; n++) begin
            chk("busy", busy, 1);
            chk("valid_early", resultValid, 0);
            if (n < S) begin
                chk("streamEn", streamEn, 1);
                chk("sel", sel, 64'(n % 4));
            end else begin
                chk("streamEn_drain", streamEn, 0);
                chk("sel_drain", sel, 0);
            end
            if (n <= L) chk("counts_cleared", results, 0);
            if (n == abort_n) begin
                rst = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_streamEn", streamEn, 0);
                chk("abort_sel", sel, 0);
                chk("abort_results", results, 0);
                chk("abort_valid", resultValid, 0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_idle_busy", busy, 0);
                chk("abort_idle_valid", resultValid, 0);
                return;
            end
            start = (pat == 2 && n == 5);
            drive(pat, n + 1);
            @(posedge clk); #1;
        end
        last_exp = pack_model();
        exp_q.push_back(last_exp);
        chk("done_valid", resultValid, 1);
        chk("done_busy", busy, 0);
        chk("done_streamEn", streamEn, 0);
        for (int d = 0; d <= bp; d++) begin
            resultReady   = (d == bp);
            start         = (pat == 2 && d == 0);
            outputStreams = N'($urandom);
            outputWriteEn = 1'b1;
            @(posedge clk); #1;
            if (d < bp) chk("bp_valid", resultValid, 1);
        end
        resultReady = 1'b0;
        start       = 1'b0;
        chk("hs_valid_low", resultValid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_results_held", results, last_exp);
    endtask

    // Scoreboard monitor: pops one expected vector per valid period and
    // checks results on every cycle resultValid is high.
    initial begin
        bit               in_done;
        logic [N*CW-1:0]  cur;
        in_done = 0;
        cur     = '0;
        forever begin
            @(negedge clk);
            if (rst && resultValid) begin
                if (!in_done) begin
                    in_done = 1;
                    if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                    else cur = exp_q.pop_front();
                end
                chk("results", results, cur);
            end else begin
                in_done = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start         = 1'($urandom);
            outputStreams = N'($urandom);
            outputWriteEn = 1'($urandom);
            resultReady   = 1'($urandom);
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_streamEn", streamEn, 0);
            chk("rst_sel", sel, 0);
            chk("rst_results", results, 0);
            chk("rst_valid", resultValid, 0);
        end
        start       = 1'b0;
        resultReady = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", resultValid, 0);

        run_pass(0, 0, -1);   // all ones
        run_pass(1, 2, -1);   // window boundaries
        run_pass(2, 3, -1);   // busy start and qualifier
        run_pass(3, 5, -1);   // backpressure with random data
        run_pass(0, 0, -1);   // back-to-back: counts must clear
        run_pass(3, 0, 7);    // mid-pass reset
        run_pass(0, 1, -1);   // full pass after abort
        for (int i = 0; i < 4; i++) run_pass(3, int'($urandom_range(0, 3)), -1);

        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_matmul_sequencer.md
# sc_matmul_sequencer

Controller that runs one stochastic matrix-multiply pass and turns its output bitstreams back into binary counts. On a start request it enables the upstream stochastic number generators and drives the dot-product mux select for a fixed stream length. It then waits out the datapath latency while counting the ones on every output stream. The finished M×O count vector is presented on a valid/ready handshake for the write-back stage.

## Interface
- BATCH_SIZE, 4, M (rows of result)
- OUTPUT_FEATURES, 4, O (columns of result)
- SELECT_WIDTH, 2, width of dot-product mux select; log2 of INPUT_FEATURES
- STREAM_LENGTH, 256, bitstream length in cycles; multiple of 2^SELECT_WIDTH, ≥ 2^SELECT_WIDTH
- LATENCY, 2, cycles from datapath input to outputStreams; ≥ 1
- COUNT_WIDTH, clog2(STREAM_LENGTH+1), width of each result count

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a pass; honoured only in IDLE
- busy  out  1  high in STREAM and DRAIN
- streamEn  out  1  enables upstream SNGs; high only in STREAM
- sel  out  SELECT_WIDTH  dot-product mux select
- outputStreams  in  BATCH_SIZE*OUTPUT_FEATURES  datapath result bits, index i*O+j
- outputWriteEn  in  1  datapath output qualifier; bit counted only when high
- results  out  BATCH_SIZE*OUTPUT_FEATURES*COUNT_WIDTH  count k at [k*COUNT_WIDTH +: COUNT_WIDTH]
- resultValid  out  1  results complete and stable
- resultReady  in  1  consumer accepts results

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: start=1 at an edge → STREAM. All counts and the cycle counter clear on that same edge.
- STREAM: lasts exactly STREAM_LENGTH cycles. streamEn=1. sel = cycle counter[SELECT_WIDTH-1:0], giving 0,1,2,… wrapping. The final cycle → DRAIN.
- DRAIN: lasts exactly LATENCY cycles, then → DONE. streamEn=0.
- DONE: resultValid=1. An edge with resultReady=1 → IDLE. resultValid falls and results hold their values until the next start.
- sel=0 outside STREAM.
- Count window: a LATENCY-deep shift register delays streamEn to produce countEn.
- Count rule: count k increments at an edge when countEn=1, outputWriteEn=1, and outputStreams[k]=1.
- Overflow: counts never exceed STREAM_LENGTH, so there is no overflow and no saturation logic.
- Ignored inputs: start in STREAM, DRAIN or DONE has no effect. resultReady outside DONE has no effect.
- rst low at any time: immediately → IDLE. Shift register, counters and all outputs clear. Any pass in progress is aborted and no resultValid is produced.

## Timing
- Reset values: busy=0, streamEn=0, sel=0, results=0, resultValid=0.
- Let edge k be the start-accept edge, with S=STREAM_LENGTH and L=LATENCY.
- STREAM spans the cycles following edges k … k+S-1.
- Count edges are k+L+1 … k+S+L, exactly S edges. Output of stream cycle n is sampled at edge k+n+L+1.
- DONE is entered at edge k+S+L. resultValid is high S+L cycles after edge k, and results already include the final count.
- Minimum pass period: start to handshake to start is S+L+2 cycles (start, one DONE cycle, one IDLE cycle).
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.

## Test plan
Defaults for all scenarios: M=2, O=2, SELECT_WIDTH=2, S=16, L=2, outputWriteEn=1.
- Reset:
  - Stimulus: rst low with random inputs.
  - Required: every output 0. After release, IDLE with busy=0.
- All-ones:
  - Stimulus: outputStreams=4'b1111 throughout; start pulse at edge k.
  - Required:
    - busy from k; streamEn high for 16 cycles.
    - sel sequence 0,1,2,3 repeated 4 times.
    - resultValid at edge k+18; results all 16.
- Window boundaries:
  - Stimulus:
    - bit0=1 throughout.
    - bit1 toggles, high on odd window edges.
    - bit2=0.
    - bit3=1 only on window edges 1–4 and on edges k+1..k+2 (outside the window).
  - Required: results {16, 8, 0, 4}.
- Busy start and qualifier:
  - Stimulus:
    - start re-pulsed during STREAM and during DONE.
    - outputWriteEn low for 3 window edges with all-ones data.
  - Required:
    - No restart and no count clear.
    - Counts are 13.
- Backpressure:
  - Stimulus: resultReady low for 5 cycles in DONE, then high 1 cycle.
  - Required:
    - resultValid and results stable for all 6 cycles.
    - IDLE after the handshake.
    - The next start clears counts to 0.
- Mid-pass reset:
  - Stimulus: rst low at stream cycle 7.
  - Required:
    - Immediate IDLE; busy=0, streamEn=0, counts 0.
    - A following full pass yields correct counts.
